reorder_buffer_param: RTL and testbench

// AXI-read reorder buffer that sits between a read initiator (s_*) and an out-of-order slave (m_*).

---
 rtl/rob_pkg.sv | 26 ++
 rtl/show_ahead_fifo.sv | 89 ++++++++
 rtl/reorder_buffer_param.sv | 202 ++++++++++++++++++++
 tb/tb_reorder_buffer_param.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Shared definitions for the AXI-read reorder buffer.
//
// Contents:
//   ROB_DEFAULT_ID_WIDTH : default AR/R ID width of the reorder buffer
//   NUM_IDS              : number of per-ID data slots at the default width
//   rresp_t              : 2-bit AXI read response, with named response codes
//   num_ids()            : slot count for an arbitrary ID width
package rob_pkg;

    localparam int ROB_DEFAULT_ID_WIDTH = 4;
    localparam int NUM_IDS              = 2 ** ROB_DEFAULT_ID_WIDTH;

    typedef logic [1:0] rresp_t;

    localparam rresp_t RRESP_OKAY   = 2'b00;
    localparam rresp_t RRESP_EXOKAY = 2'b01;
    localparam rresp_t RRESP_SLVERR = 2'b10;
    localparam rresp_t RRESP_DECERR = 2'b11;

    // There is one data slot per possible ID, so the slot count follows the
    // ID width of the instance rather than the package default.
    function automatic int num_ids(input int id_width);
        return 2 ** id_width;
    endfunction

endpackage

// File: rtl/show_ahead_fifo.sv
// Show-ahead (first-word-fall-through) FIFO.
// The oldest entry is always visible on rd_data_o while the FIFO is not empty;
// rd_en_i consumes it. A write and a read in the same cycle are accepted even
// when the FIFO is full, because the read frees the entry the write needs.
//
// Ports:
//   clk        in   clock, all logic on posedge
//   rstn_i     in   synchronous reset, active-low
//   wr_en_i    in   push wr_data_i
//   wr_data_i  in   WIDTH  data to push
//   rd_en_i    in   pop the head entry (ignored when empty)
//   rd_data_o  out  WIDTH  head entry
//   empty_o    out  no entries stored
//   full_o     out  DEPTH entries stored
//   count_o    out  $clog2(DEPTH+1)  current occupancy
module show_ahead_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rstn_i,
    input  logic                       wr_en_i,
    input  logic [WIDTH-1:0]           wr_data_i,
    input  logic                       rd_en_i,
    output logic [WIDTH-1:0]           rd_data_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_wr;
    logic             do_rd;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Qualify the requests: a pop needs data, a push needs room unless the
    // same cycle's pop makes room.
    always_comb begin
        do_rd = rd_en_i && (count != '0);
        do_wr = wr_en_i && ((count != FULL_CNT) || do_rd);
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!rstn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_rd) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage has no reset; an entry is only ever read after it was written.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data_i;
        end
    end

    assign rd_data_o = mem[rd_ptr];
    assign empty_o   = (count == '0);
    assign full_o    = (count == FULL_CNT);
    assign count_o   = count;

endmodule

// File: rtl/reorder_buffer_param.sv
// AXI-read reorder buffer between a read initiator (s_*) and a slave that may
// return read data out of order (m_*).
//
// AR requests are forwarded downstream and their IDs are recorded in issue
// order. R beats come back in any order, are parked in a per-ID slot, and are
// replayed upstream in AR order through a registered valid/ready stage. Only
// one transaction per ID may be in flight; a beat for an ID that is not
// outstanding, or a second beat for an ID already parked, is dropped and
// raises the sticky err_o.
//
// Optional feature (macro ROB_RRESP_EN): adds m_rresp_i / s_rresp_o and
// carries RRESP alongside the data. Error responses are data, not protocol
// errors, so they never set err_o.
//
// Ports:
//   clk            in   clock, all logic on posedge
//   rst            in   synchronous reset, active-high
//   s_arid_i       in   ID_WIDTH    upstream AR id
//   s_arvalid_i    in   upstream AR valid
//   s_arready_o    out  upstream AR ready
//   s_rdata_o      out  DATA_WIDTH  in-order R data (registered)
//   s_rid_o        out  ID_WIDTH    in-order R id (registered)
//   s_rvalid_o     out  in-order R valid (registered)
//   s_rready_i     in   upstream R ready
//   m_arid_o       out  ID_WIDTH    downstream AR id (equals s_arid_i)
//   m_arvalid_o    out  downstream AR valid
//   m_arready_i    in   downstream AR ready
//   m_rdata_i      in   DATA_WIDTH  downstream R data
//   m_rid_i        in   ID_WIDTH    downstream R id
//   m_rvalid_i     in   downstream R valid
//   m_rready_o     out  downstream R ready (low only during reset)
//   m_rresp_i      in   2           downstream R response (ROB_RRESP_EN only)
//   s_rresp_o      out  2           in-order R response (ROB_RRESP_EN only)
//   outstanding_o  out  $clog2(DEPTH+1)  entries in the order queue
//   err_o          out  sticky protocol error
module reorder_buffer_param
    import rob_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = ROB_DEFAULT_ID_WIDTH,
    parameter int DEPTH      = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ID_WIDTH-1:0]        s_arid_i,
    input  logic                       s_arvalid_i,
    output logic                       s_arready_o,
    output logic [DATA_WIDTH-1:0]      s_rdata_o,
    output logic [ID_WIDTH-1:0]        s_rid_o,
    output logic                       s_rvalid_o,
    input  logic                       s_rready_i,
    output logic [ID_WIDTH-1:0]        m_arid_o,
    output logic                       m_arvalid_o,
    input  logic                       m_arready_i,
    input  logic [DATA_WIDTH-1:0]      m_rdata_i,
    input  logic [ID_WIDTH-1:0]        m_rid_i,
    input  logic                       m_rvalid_i,
    output logic                       m_rready_o,
`ifdef ROB_RRESP_EN
    input  rresp_t                     m_rresp_i,
    output rresp_t                     s_rresp_o,
`endif
    output logic [$clog2(DEPTH+1)-1:0] outstanding_o,
    output logic                       err_o
);

    localparam int SLOTS = num_ids(ID_WIDTH);
    localparam int CW    = $clog2(DEPTH + 1);

    // busy: an AR for this ID has been accepted and its beat not yet loaded
    // into the output register. stored: the beat for this ID is parked.
    logic [SLOTS-1:0]      busy;
    logic [SLOTS-1:0]      stored;
    logic [DATA_WIDTH-1:0] slot_data [SLOTS];
`ifdef ROB_RRESP_EN
    rresp_t                slot_resp [SLOTS];
`endif

    logic [ID_WIDTH-1:0]   head_id;
    logic                  q_empty;
    logic                  q_full;
    logic [CW-1:0]         q_count;

    logic                  ar_ok;
    logic                  ar_fire;
    logic                  r_accept;
    logic                  out_free;
    logic                  head_hit;
    logic                  load;
    logic                  bypass;
    logic                  store;
    logic                  proto_err;
    logic                  slot_open;

    // The issue order of accepted ARs; the head is the ID owed upstream next.
    show_ahead_fifo #(
        .WIDTH (ID_WIDTH),
        .DEPTH (DEPTH)
    ) u_order_q (
        .clk       (clk),
        .rstn_i    (~rst),
        .wr_en_i   (ar_fire),
        .wr_data_i (s_arid_i),
        .rd_en_i   (load),
        .rd_data_o (head_id),
        .empty_o   (q_empty),
        .full_o    (q_full),
        .count_o   (q_count)
    );

    // AR gating and R-side decisions. An AR is held off while its ID is still
    // busy; because busy is a register, an ID released this cycle still
    // stalls for this cycle. A beat for the head ID bypasses the slots only
    // when the output register can take it now; otherwise it is parked like
    // any other beat and released from its slot on a later cycle.
    always_comb begin
        ar_ok       = !q_full && !busy[s_arid_i];
        m_arvalid_o = s_arvalid_i && ar_ok;
        s_arready_o = m_arready_i && ar_ok;
        m_arid_o    = s_arid_i;
        ar_fire     = s_arvalid_i && m_arready_i && ar_ok;

        m_rready_o  = !rst;
        r_accept    = m_rvalid_i && m_rready_o;
        out_free    = !s_rvalid_o || s_rready_i;

        head_hit    = r_accept && !q_empty && (m_rid_i == head_id) && !stored[head_id];
        load        = !q_empty && (stored[head_id] || head_hit) && out_free;
        bypass      = head_hit && load;

        slot_open   = busy[m_rid_i] && !stored[m_rid_i];
        store       = r_accept && !bypass && slot_open;
        proto_err   = r_accept && !bypass && !slot_open;
    end

    // Per-ID status bits. Setting and clearing never target the same ID in one
    // cycle: a busy ID cannot be re-requested, and a parked head cannot be
    // stored again.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= '0;
            stored <= '0;
        end else begin
            if (ar_fire) begin
                busy[s_arid_i] <= 1'b1;
            end
            if (store) begin
                stored[m_rid_i] <= 1'b1;
            end
            if (load) begin
                busy[head_id]   <= 1'b0;
                stored[head_id] <= 1'b0;
            end
        end
    end

    // Parked beat payloads. No reset: a slot is only read when its stored bit
    // says it holds a beat.
    always_ff @(posedge clk) begin
        if (store) begin
            slot_data[m_rid_i] <= m_rdata_i;
`ifdef ROB_RRESP_EN
            slot_resp[m_rid_i] <= m_rresp_i;
`endif
        end
    end

    // Upstream R register. It reloads whenever the head is releasable and the
    // register is empty or being emptied, which sustains one beat per cycle;
    // otherwise it holds its contents until the initiator takes them.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_rvalid_o <= 1'b0;
            s_rdata_o  <= '0;
            s_rid_o    <= '0;
`ifdef ROB_RRESP_EN
            s_rresp_o  <= RRESP_OKAY;
`endif
        end else if (load) begin
            s_rvalid_o <= 1'b1;
            s_rid_o    <= head_id;
            s_rdata_o  <= bypass ? m_rdata_i : slot_data[head_id];
`ifdef ROB_RRESP_EN
            s_rresp_o  <= bypass ? m_rresp_i : slot_resp[head_id];
`endif
        end else if (s_rready_i) begin
            s_rvalid_o <= 1'b0;
        end
    end

    // Sticky protocol error: unexpected or duplicate beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_o <= 1'b0;
        end else if (proto_err) begin
            err_o <= 1'b1;
        end
    end

    assign outstanding_o = q_count;

endmodule

// File: tb/tb_reorder_buffer_param.sv
`timescale 1ns/1ps
module tb_reorder_buffer_param;

    localparam int DW    = 32;
    localparam int IW    = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic [IW-1:0] s_arid_i;
    logic          s_arvalid_i;
    logic          s_arready_o;
    logic [DW-1:0] s_rdata_o;
    logic [IW-1:0] s_rid_o;
    logic          s_rvalid_o;
    logic          s_rready_i;
    logic [IW-1:0] m_arid_o;
    logic          m_arvalid_o;
    logic          m_arready_i;
    logic [DW-1:0] m_rdata_i;
    logic [IW-1:0] m_rid_i;
    logic          m_rvalid_i;
    logic          m_rready_o;
    logic [CW-1:0] outstanding_o;
    logic          err_o;
`ifdef ROB_RRESP_EN
    logic [1:0]    m_rresp_i = 2'b00;
    logic [1:0]    s_rresp_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    reorder_buffer_param #(
        .DATA_WIDTH (DW),
        .ID_WIDTH   (IW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_arid_i      (s_arid_i),
        .s_arvalid_i   (s_arvalid_i),
        .s_arready_o   (s_arready_o),
        .s_rdata_o     (s_rdata_o),
        .s_rid_o       (s_rid_o),
        .s_rvalid_o    (s_rvalid_o),
        .s_rready_i    (s_rready_i),
        .m_arid_o      (m_arid_o),
        .m_arvalid_o   (m_arvalid_o),
        .m_arready_i   (m_arready_i),
        .m_rdata_i     (m_rdata_i),
        .m_rid_i       (m_rid_i),
        .m_rvalid_i    (m_rvalid_i),
        .m_rready_o    (m_rready_o),
`ifdef ROB_RRESP_EN
        .m_rresp_i     (m_rresp_i),
        .s_rresp_o     (s_rresp_o),
`endif
        .outstanding_o (outstanding_o),
        .err_o         (err_o)
    );

    // One table row is one clock cycle: the inputs held for that cycle, the
    // AR ready expected during it (-1 = not checked), and the registered
    // outputs expected just after its clock edge.
    typedef struct {
        logic          arv;
        logic [IW-1:0] arid;
        logic          rv;
        logic [IW-1:0] rid;
        logic [DW-1:0] rdata;
        logic          rready;
        int            ear;
        logic          erv;
        logic [IW-1:0] erid;
        logic [DW-1:0] erdata;
        logic [CW-1:0] eout;
    } vec_t;

    vec_t vecs[$];

    // Reference model for the random phase: every accepted AR becomes a
    // numbered transaction. ord_q is the order owed upstream, ds_q the
    // transactions the downstream slave has not answered yet.
    int            ord_q[$];
    int            ds_q[$];
    int            txn_id[int];
    logic [DW-1:0] txn_data[int];
    int            txn_next = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic addVec(input int arv, input int arid, input int rv, input int rid,
                          input int rdata, input int rready, input int ear,
                          input int erv, input int erid, input int erdata, input int eout);
        vec_t v;
        v.arv    = 1'(arv);
        v.arid   = IW'(arid);
        v.rv     = 1'(rv);
        v.rid    = IW'(rid);
        v.rdata  = DW'(rdata);
        v.rready = 1'(rready);
        v.ear    = ear;
        v.erv    = 1'(erv);
        v.erid   = IW'(erid);
        v.erdata = DW'(erdata);
        v.eout   = CW'(eout);
        vecs.push_back(v);
    endtask

    task automatic drive(input int arv, input int arid, input int rv, input int rid,
                         input int rdata, input int rready);
        s_arvalid_i = 1'(arv);
        s_arid_i    = IW'(arid);
        m_arready_i = 1'b1;
        m_rvalid_i  = 1'(rv);
        m_rid_i     = IW'(rid);
        m_rdata_i   = DW'(rdata);
        s_rready_i  = 1'(rready);
    endtask

    task automatic applyStimulus(input vec_t v);
        drive(int'(v.arv), int'(v.arid), int'(v.rv), int'(v.rid), int'(v.rdata), int'(v.rready));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("rst.m_rready_low", 64'(m_rready_o), 64'(0));
        tick();
        checkOutput("rst.rvalid", 64'(s_rvalid_o), 64'(0));
        checkOutput("rst.rid", 64'(s_rid_o), 64'(0));
        checkOutput("rst.rdata", 64'(s_rdata_o), 64'(0));
        checkOutput("rst.outstanding", 64'(outstanding_o), 64'(0));
        checkOutput("rst.err", 64'(err_o), 64'(0));
        rst = 1'b0;
        #1;
        checkOutput("rst.m_rready_high", 64'(m_rready_o), 64'(1));
    endtask

    task automatic runTable();
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            #1;
            if (vecs[i].ear >= 0) begin
                checkOutput($sformatf("v%0d.arready", i), 64'(s_arready_o), 64'(vecs[i].ear));
                checkOutput($sformatf("v%0d.m_arvalid", i), 64'(m_arvalid_o),
                            64'(vecs[i].arv && (vecs[i].ear == 1)));
            end
            tick();
            checkOutput($sformatf("v%0d.rvalid", i), 64'(s_rvalid_o), 64'(vecs[i].erv));
            if (vecs[i].erv) begin
                checkOutput($sformatf("v%0d.rid", i), 64'(s_rid_o), 64'(vecs[i].erid));
                checkOutput($sformatf("v%0d.rdata", i), 64'(s_rdata_o), 64'(vecs[i].erdata));
            end
            checkOutput($sformatf("v%0d.outstanding", i), 64'(outstanding_o), 64'(vecs[i].eout));
            checkOutput($sformatf("v%0d.err", i), 64'(err_o), 64'(0));
        end
    endtask

    // One random cycle: random AR/R traffic, a downstream slave answering its
    // pending requests in random order, and upstream beats compared against
    // the issue order.
    task automatic randCycle(input bit busy_traffic);
        int   k;
        int   t;
        int   ds_t;
        bit   ds_fire;
        bit   reissue;
        ds_fire     = 1'b0;
        ds_t        = 0;
        s_arvalid_i = busy_traffic && ($urandom_range(0, 2) != 0);
        s_arid_i    = IW'($urandom_range(0, 15));
        m_arready_i = busy_traffic ? ($urandom_range(0, 3) != 0) : 1'b1;
        s_rready_i  = busy_traffic ? ($urandom_range(0, 3) != 0) : 1'b1;
        m_rvalid_i  = 1'b0;
        if (ds_q.size() > 0 && $urandom_range(0, 1) == 1) begin
            k           = $urandom_range(0, ds_q.size() - 1);
            ds_t        = ds_q[k];
            ds_q.delete(k);
            ds_fire     = 1'b1;
            m_rvalid_i  = 1'b1;
            m_rid_i     = IW'(txn_id[ds_t]);
            m_rdata_i   = $urandom;
            txn_data[ds_t] = m_rdata_i;
        end
        #1;
        if (ds_fire) begin
            checkOutput("rnd.m_rready", 64'(m_rready_o), 64'(1));
        end
        if (s_rvalid_o && s_rready_i) begin
            checkOutput("rnd.beat_without_request", 64'(ord_q.size() == 0), 64'(0));
            if (ord_q.size() > 0) begin
                t = ord_q.pop_front();
                checkOutput("rnd.rid_order", 64'(s_rid_o), 64'(txn_id[t]));
                checkOutput("rnd.beat_before_return", 64'(!txn_data.exists(t)), 64'(0));
                if (txn_data.exists(t)) begin
                    checkOutput("rnd.rdata", 64'(s_rdata_o), 64'(txn_data[t]));
                    txn_data.delete(t);
                end
                txn_id.delete(t);
            end
        end
        if (s_arvalid_i && s_arready_o) begin
            reissue = 1'b0;
            foreach (ds_q[j]) begin
                if (txn_id[ds_q[j]] == int'(s_arid_i)) begin
                    reissue = 1'b1;
                end
            end
            if (ds_fire && txn_id[ds_t] == int'(s_arid_i)) begin
                reissue = 1'b1;
            end
            checkOutput("rnd.ar_accepted_while_busy", 64'(reissue), 64'(0));
            checkOutput("rnd.m_arid", 64'(m_arid_o), 64'(s_arid_i));
            txn_id[txn_next] = int'(s_arid_i);
            ord_q.push_back(txn_next);
            ds_q.push_back(txn_next);
            txn_next++;
        end
        tick();
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);

        // In order: three ARs, beats returned in the same order, each one
        // presented the cycle after it arrives.
        addVec(1, 1, 0, 0, 0, 1,  1, 0, 0, 0, 1);
        addVec(1, 2, 0, 0, 0, 1,  1, 0, 0, 0, 2);
        addVec(1, 3, 0, 0, 0, 1,  1, 0, 0, 0, 3);
        addVec(0, 0, 1, 1, 'h11, 1, -1, 1, 1, 'h11, 2);
        addVec(0, 0, 1, 2, 'h22, 1, -1, 1, 2, 'h22, 1);
        addVec(0, 0, 1, 3, 'h33, 1, -1, 1, 3, 'h33, 0);
        addVec(0, 0, 0, 0, 0, 1, -1, 0, 0, 0, 0);
        // Reorder: beats come back 2,9,5; replayed 5,9,2 on consecutive cycles.
        addVec(1, 5, 0, 0, 0, 1,  1, 0, 0, 0, 1);
        addVec(1, 9, 0, 0, 0, 1,  1, 0, 0, 0, 2);
        addVec(1, 2, 0, 0, 0, 1,  1, 0, 0, 0, 3);
        addVec(0, 0, 1, 2, 'hC, 1, -1, 0, 0, 0, 3);
        addVec(0, 0, 1, 9, 'hB, 1, -1, 0, 0, 0, 3);
        addVec(0, 0, 1, 5, 'hA, 1, -1, 1, 5, 'hA, 2);
        addVec(0, 0, 0, 0, 0, 1, -1, 1, 9, 'hB, 1);
        addVec(0, 0, 0, 0, 0, 1, -1, 1, 2, 'hC, 0);
        addVec(0, 0, 0, 0, 0, 1, -1, 0, 0, 0, 0);
        // Backpressure: upstream stalls 10 cycles with three beats available.
        addVec(1, 1, 0, 0, 0, 0,  1, 0, 0, 0, 1);
        addVec(1, 2, 0, 0, 0, 0,  1, 0, 0, 0, 2);
        addVec(1, 3, 0, 0, 0, 0,  1, 0, 0, 0, 3);
        addVec(0, 0, 1, 3, 'h31, 0, -1, 0, 0, 0, 3);
        addVec(0, 0, 1, 2, 'h32, 0, -1, 0, 0, 0, 3);
        addVec(0, 0, 1, 1, 'h30, 0, -1, 1, 1, 'h30, 2);
        for (int i = 0; i < 10; i++) begin
            addVec(0, 0, 0, 0, 0, 0, -1, 1, 1, 'h30, 2);
        end
        addVec(0, 0, 0, 0, 0, 1, -1, 1, 2, 'h32, 1);
        addVec(0, 0, 0, 0, 0, 1, -1, 1, 3, 'h31, 0);
        addVec(0, 0, 0, 0, 0, 1, -1, 0, 0, 0, 0);
        // Limits: queue full at 4, busy-ID stall, reissue once delivered.
        addVec(1, 1, 0, 0, 0, 1,  1, 0, 0, 0, 1);
        addVec(1, 2, 0, 0, 0, 1,  1, 0, 0, 0, 2);
        addVec(1, 3, 0, 0, 0, 1,  1, 0, 0, 0, 3);
        addVec(1, 4, 0, 0, 0, 1,  1, 0, 0, 0, 4);
        addVec(1, 5, 0, 0, 0, 1,  0, 0, 0, 0, 4);
        addVec(1, 2, 0, 0, 0, 1,  0, 0, 0, 0, 4);
        addVec(1, 1, 1, 1, 'h41, 1, 0, 1, 1, 'h41, 3);
        addVec(1, 1, 0, 0, 0, 1,  1, 0, 0, 0, 4);
        addVec(1, 1, 1, 2, 'h42, 1, 0, 1, 2, 'h42, 3);
        addVec(0, 0, 1, 3, 'h43, 1, -1, 1, 3, 'h43, 2);
        addVec(0, 0, 1, 4, 'h44, 1, -1, 1, 4, 'h44, 1);
        addVec(0, 0, 1, 1, 'h45, 1, -1, 1, 1, 'h45, 0);
        addVec(0, 0, 0, 0, 0, 1, -1, 0, 0, 0, 0);

        @(posedge clk);
        #1;
        doReset();
        runTable();

        // Unexpected ID: dropped, error sticks.
        drive(0, 0, 1, 7, 'h77, 1);
        tick();
        checkOutput("err.unexpected", 64'(err_o), 64'(1));
        checkOutput("err.unexpected_rvalid", 64'(s_rvalid_o), 64'(0));
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 1);
            tick();
            checkOutput($sformatf("err.sticky%0d", i), 64'(err_o), 64'(1));
        end

        // Duplicate beat: dropped without overwriting the parked data.
        doReset();
        drive(1, 3, 0, 0, 0, 1);
        tick();
        drive(1, 4, 0, 0, 0, 1);
        tick();
        checkOutput("dup.outstanding", 64'(outstanding_o), 64'(2));
        drive(0, 0, 1, 4, 'h54, 1);
        tick();
        checkOutput("dup.first_ok", 64'(err_o), 64'(0));
        drive(0, 0, 1, 4, 'h55, 1);
        tick();
        checkOutput("dup.err", 64'(err_o), 64'(1));
        drive(0, 0, 1, 3, 'h53, 1);
        tick();
        checkOutput("dup.rid3", 64'(s_rid_o), 64'(3));
        checkOutput("dup.data3", 64'(s_rdata_o), 64'('h53));
        drive(0, 0, 0, 0, 0, 1);
        tick();
        checkOutput("dup.rid4", 64'(s_rid_o), 64'(4));
        checkOutput("dup.data4_kept", 64'(s_rdata_o), 64'('h54));
        checkOutput("dup.outstanding_end", 64'(outstanding_o), 64'(0));

        // Reset with three transactions outstanding.
        doReset();
        drive(1, 1, 0, 0, 0, 1);
        tick();
        drive(1, 2, 0, 0, 0, 1);
        tick();
        drive(1, 3, 0, 0, 0, 1);
        tick();
        checkOutput("midrst.before", 64'(outstanding_o), 64'(3));
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 1);
        #1;
        checkOutput("midrst.m_rready", 64'(m_rready_o), 64'(0));
        tick();
        rst = 1'b0;
        checkOutput("midrst.outstanding", 64'(outstanding_o), 64'(0));
        checkOutput("midrst.rvalid", 64'(s_rvalid_o), 64'(0));
        drive(1, 1, 0, 0, 0, 1);
        #1;
        checkOutput("midrst.fresh_ar", 64'(s_arready_o), 64'(1));
        tick();
        checkOutput("midrst.after_ar", 64'(outstanding_o), 64'(1));

        // Random traffic against the order model, then a bounded drain.
        doReset();
        for (int i = 0; i < 3000; i++) begin
            randCycle(1'b1);
        end
        for (int i = 0; i < 400 && (ord_q.size() > 0 || ds_q.size() > 0); i++) begin
            randCycle(1'b0);
        end
        checkOutput("drain.pending_upstream", 64'(ord_q.size()), 64'(0));
        checkOutput("drain.pending_downstream", 64'(ds_q.size()), 64'(0));
        checkOutput("drain.outstanding", 64'(outstanding_o), 64'(0));
        checkOutput("drain.rvalid", 64'(s_rvalid_o), 64'(0));
        checkOutput("drain.err", 64'(err_o), 64'(0));
        $display("[TB] random phase issued %0d transactions", txn_next);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("[TB] FAIL watchdog timeout actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
